fc_l2_port_arbiter: RTL and testbench

FC_L2_PORT_ARBITER -- requirements
Module: fc_l2_port_arbiter

---
 rtl/fc_l2_arb_pkg.sv | 14 +
 rtl/fc_l2_arb_idfifo.sv | 61 ++++++
 rtl/fc_l2_port_arbiter.sv | 115 +++++++++++
 tb/tb_fc_l2_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_l2_arb_pkg.sv
// Shared types and default sizing for the FC-to-L2 port arbiter.
// Source IDs identify which requester a returning L2 response belongs to.
package fc_l2_arb_pkg;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } src_e;

  localparam int unsigned DEF_ADDR_WIDTH      = 32;
  localparam int unsigned DEF_DATA_WIDTH      = 32;
  localparam int unsigned DEF_MAX_OUTSTANDING = 2;

endpackage

// File: rtl/fc_l2_arb_idfifo.sv
// In-order FIFO of source IDs for granted L2 requests awaiting a response.
// A push is accepted while full if a pop happens in the same cycle.
module fc_l2_arb_idfifo
  import fc_l2_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_MAX_OUTSTANDING
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  src_e                       pushId_i,
  input  logic                       pop_i,
  output src_e                       popId_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  src_e             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] incPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o   = (r_count == CNT_W'(DEPTH));
  assign empty_o  = (r_count == '0);
  assign w_doPop  = pop_i && !empty_o;
  assign w_doPush = push_i && (!full_o || w_doPop);
  assign popId_o  = r_mem[r_rdPtr];
  assign count_o  = r_count;

  always_ff @(posedge clk_i) begin
    if (w_doPush) r_mem[r_wrPtr] <= pushId_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= incPtr(r_wrPtr);
      if (w_doPop)  r_rdPtr <= incPtr(r_rdPtr);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fc_l2_port_arbiter.sv
// Arbitrates the FC instruction and data ports onto one shared L2 master port
// and routes in-order L2 responses back to the requester that issued them.
module fc_l2_port_arbiter
  import fc_l2_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 instr_req_i,
  input  logic [ADDR_WIDTH-1:0]                instr_add_i,
  output logic                                 instr_gnt_o,
  output logic                                 instr_r_valid_o,
  output logic [DATA_WIDTH-1:0]                instr_r_rdata_o,
  input  logic                                 data_req_i,
  input  logic [ADDR_WIDTH-1:0]                data_add_i,
  input  logic                                 data_wen_i,
  input  logic [DATA_WIDTH-1:0]                data_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]              data_be_i,
  output logic                                 data_gnt_o,
  output logic                                 data_r_valid_o,
  output logic [DATA_WIDTH-1:0]                data_r_rdata_o,
  output logic                                 l2_req_o,
  output logic [ADDR_WIDTH-1:0]                l2_add_o,
  output logic                                 l2_wen_o,
  output logic [DATA_WIDTH-1:0]                l2_wdata_o,
  output logic [DATA_WIDTH/8-1:0]              l2_be_o,
  input  logic                                 l2_gnt_i,
  input  logic                                 l2_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                l2_r_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 err_o
);

  src_e r_prio;
  src_e r_lockSrc;
  logic r_locked;
  logic r_err;
  src_e w_sel;
  src_e w_other;
  src_e w_popId;
  logic w_selReq;
  logic w_full;
  logic w_empty;
  logic w_xfer;
  logic w_pop;

  // A stalled request keeps its selection until granted; otherwise the
  // priority register only breaks ties.
  always_comb begin
    w_sel = SRC_INSTR;
    if (r_locked)                      w_sel = r_lockSrc;
    else if (instr_req_i && data_req_i) w_sel = r_prio;
    else if (data_req_i)               w_sel = SRC_DATA;
  end

  assign w_other  = (w_sel == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
  assign w_selReq = (w_sel == SRC_DATA) ? data_req_i : instr_req_i;
  assign l2_req_o = !rst_i && w_selReq && (!w_full || l2_r_valid_i);
  assign w_xfer   = l2_req_o && l2_gnt_i;
  assign w_pop    = !rst_i && l2_r_valid_i && !w_empty;

  assign instr_gnt_o = w_xfer && (w_sel == SRC_INSTR);
  assign data_gnt_o  = w_xfer && (w_sel == SRC_DATA);

  always_comb begin
    l2_add_o   = instr_add_i;
    l2_wen_o   = 1'b1;
    l2_wdata_o = '0;
    l2_be_o    = '1;
    if (w_sel == SRC_DATA) begin
      l2_add_o   = data_add_i;
      l2_wen_o   = data_wen_i;
      l2_wdata_o = data_wdata_i;
      l2_be_o    = data_be_i;
    end
  end

  assign instr_r_valid_o = w_pop && (w_popId == SRC_INSTR);
  assign data_r_valid_o  = w_pop && (w_popId == SRC_DATA);
  assign instr_r_rdata_o = l2_r_rdata_i;
  assign data_r_rdata_o  = l2_r_rdata_i;
  assign err_o           = r_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_prio    <= SRC_INSTR;
      r_lockSrc <= SRC_INSTR;
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_locked  <= l2_req_o && !l2_gnt_i;
      r_lockSrc <= w_sel;
      if (w_xfer) r_prio <= w_other;
      if (l2_r_valid_i && w_empty) r_err <= 1'b1;
    end
  end

  fc_l2_arb_idfifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_idFifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_xfer),
    .pushId_i(w_sel),
    .pop_i   (w_pop),
    .popId_o (w_popId),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (outstanding_o)
  );

endmodule

// File: tb/tb_fc_l2_port_arbiter.sv
// Scoreboard bench for fc_l2_port_arbiter: stimulus queues expected L2 transfers
// and responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_fc_l2_port_arbiter;
  import fc_l2_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        instr_req_i = 1'b0;
  logic [31:0] instr_add_i = '0;
  logic        instr_gnt_o, instr_r_valid_o;
  logic [31:0] instr_r_rdata_o;
  logic        data_req_i = 1'b0;
  logic [31:0] data_add_i = '0;
  logic        data_wen_i = 1'b1;
  logic [31:0] data_wdata_i = '0;
  logic [3:0]  data_be_i = '0;
  logic        data_gnt_o, data_r_valid_o;
  logic [31:0] data_r_rdata_o;
  logic        l2_req_o, l2_wen_o;
  logic [31:0] l2_add_o, l2_wdata_o;
  logic [3:0]  l2_be_o;
  logic        l2_gnt_i = 1'b0;
  logic        l2_r_valid_i = 1'b0;
  logic [31:0] l2_r_rdata_i = '0;
  logic [1:0]  outstanding_o;
  logic        err_o;

  typedef struct {
    logic        isData;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
  } gntExp_t;

  typedef struct {
    logic        isData;
    logic [31:0] data;
  } rspExp_t;

  gntExp_t     gntQ[$];
  rspExp_t     rspQ[$];
  logic [31:0] pendQ[$];
  logic        autoResp = 1'b0;
  int          nTests = 0;
  int          nFail = 0;

  fc_l2_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_add_i(instr_add_i), .instr_gnt_o(instr_gnt_o),
    .instr_r_valid_o(instr_r_valid_o), .instr_r_rdata_o(instr_r_rdata_o),
    .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_gnt_o(data_gnt_o),
    .data_r_valid_o(data_r_valid_o), .data_r_rdata_o(data_r_rdata_o),
    .l2_req_o(l2_req_o), .l2_add_o(l2_add_o), .l2_wen_o(l2_wen_o),
    .l2_wdata_o(l2_wdata_o), .l2_be_o(l2_be_o), .l2_gnt_i(l2_gnt_i),
    .l2_r_valid_i(l2_r_valid_i), .l2_r_rdata_i(l2_r_rdata_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                               input logic dreq, input logic [31:0] daddr, input logic dwen,
                               input logic [31:0] dwdata, input logic [3:0] dbe, input logic gnt);
    instr_req_i  = ireq;
    instr_add_i  = iaddr;
    data_req_i   = dreq;
    data_add_i   = daddr;
    data_wen_i   = dwen;
    data_wdata_i = dwdata;
    data_be_i    = dbe;
    l2_gnt_i     = gnt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expGrant(input logic isData, input logic [31:0] addr, input logic wen,
                          input logic [31:0] wdata, input logic [3:0] be);
    gntExp_t g;
    g.isData = isData; g.addr = addr; g.wen = wen; g.wdata = wdata; g.be = be;
    gntQ.push_back(g);
  endtask

  task automatic expRsp(input logic isData, input logic [31:0] data);
    rspExp_t r;
    r.isData = isData; r.data = data;
    rspQ.push_back(r);
  endtask

  // Simple L2 model: answers each transfer one cycle later with address + 0x1000_0000.
  always @(negedge clk) begin
    if (autoResp && l2_req_o && l2_gnt_i) pendQ.push_back(l2_add_o + 32'h1000_0000);
  end

  always @(posedge clk) begin
    #1;
    if (autoResp) begin
      if (pendQ.size() > 0) begin
        l2_r_valid_i = 1'b1;
        l2_r_rdata_i = pendQ.pop_front();
      end else begin
        l2_r_valid_i = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    gntExp_t g;
    rspExp_t r;
    if (l2_req_o && l2_gnt_i) begin
      if (gntQ.size() == 0) begin
        checkOutput("unexpected_grant_addr", {32'h0, l2_add_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        g = gntQ.pop_front();
        checkOutput("grant_src", {62'h0, instr_gnt_o, data_gnt_o}, g.isData ? 64'h1 : 64'h2);
        checkOutput("grant_addr", {32'h0, l2_add_o}, {32'h0, g.addr});
        checkOutput("grant_wen", {63'h0, l2_wen_o}, {63'h0, g.wen});
        checkOutput("grant_wdata_be", {28'h0, l2_wdata_o, l2_be_o}, {28'h0, g.wdata, g.be});
      end
    end
    if (instr_r_valid_o || data_r_valid_o) begin
      if (rspQ.size() == 0) begin
        checkOutput("unexpected_rvalid", {62'h0, instr_r_valid_o, data_r_valid_o}, 64'h0);
      end else begin
        r = rspQ.pop_front();
        checkOutput("rsp_src", {62'h0, instr_r_valid_o, data_r_valid_o}, r.isData ? 64'h1 : 64'h2);
        checkOutput("rsp_data", {32'h0, r.isData ? data_r_rdata_o : instr_r_rdata_o}, {32'h0, r.data});
      end
    end
  end

  initial begin
    int budget;
    // Reset holds all handshake outputs low even with a request pending
    applyStimulus(1'b1, 32'h1C00_0000, 1'b1, 32'h0000_1000, 1'b1, 32'h0, 4'hF, 1'b1);
    l2_r_valid_i = 1'b1;
    repeat (2) step();
    @(negedge clk);
    checkOutput("reset_handshake", {59'h0, l2_req_o, instr_gnt_o, data_gnt_o, instr_r_valid_o, data_r_valid_o}, 64'h0);
    step();
    rst_i = 1'b0;
    l2_r_valid_i = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    checkOutput("reset_state", {61'h0, outstanding_o, err_o}, 64'h0);

    // Two back-to-back instruction fetches
    step();
    autoResp = 1'b1;
    expGrant(1'b0, 32'h1C00_0000, 1'b1, 32'h0, 4'hF);
    expRsp(1'b0, 32'h2C00_0000);
    applyStimulus(1'b1, 32'h1C00_0000, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b1);
    step();
    expGrant(1'b0, 32'h1C00_0004, 1'b1, 32'h0, 4'hF);
    expRsp(1'b0, 32'h2C00_0004);
    applyStimulus(1'b1, 32'h1C00_0004, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    checkOutput("fetch_outstanding_mid", {62'h0, outstanding_o}, 64'h1);
    repeat (2) step();
    @(negedge clk);
    checkOutput("fetch_outstanding_end", {62'h0, outstanding_o}, 64'h0);

    // Continuous conflict alternates I, D, I, D starting from reset priority
    step(); rst_i = 1'b1;
    step(); rst_i = 1'b0;
    expGrant(1'b0, 32'h1C00_0100, 1'b1, 32'h0, 4'hF);
    expRsp(1'b0, 32'h2C00_0100);
    applyStimulus(1'b1, 32'h1C00_0100, 1'b1, 32'h0000_2000, 1'b0, 32'hDEAD_BEEF, 4'hF, 1'b1);
    step();
    expGrant(1'b1, 32'h0000_2000, 1'b0, 32'hDEAD_BEEF, 4'hF);
    expRsp(1'b1, 32'h1000_2000);
    applyStimulus(1'b1, 32'h1C00_0104, 1'b1, 32'h0000_2000, 1'b0, 32'hDEAD_BEEF, 4'hF, 1'b1);
    step();
    expGrant(1'b0, 32'h1C00_0104, 1'b1, 32'h0, 4'hF);
    expRsp(1'b0, 32'h2C00_0104);
    applyStimulus(1'b1, 32'h1C00_0104, 1'b1, 32'h0000_2004, 1'b1, 32'h1234_5678, 4'h3, 1'b1);
    step();
    expGrant(1'b1, 32'h0000_2004, 1'b1, 32'h1234_5678, 4'h3);
    expRsp(1'b1, 32'h1000_2004);
    applyStimulus(1'b1, 32'h1C00_0108, 1'b1, 32'h0000_2004, 1'b1, 32'h1234_5678, 4'h3, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b1);
    repeat (3) step();
    @(negedge clk);
    checkOutput("rr_outstanding_end", {62'h0, outstanding_o}, 64'h0);

    // Full FIFO blocks requests until a response frees a slot in the same cycle
    autoResp = 1'b0;
    l2_r_valid_i = 1'b0;
    expGrant(1'b0, 32'h1C00_0200, 1'b1, 32'h0, 4'hF);
    applyStimulus(1'b1, 32'h1C00_0200, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b1);
    step();
    expGrant(1'b0, 32'h1C00_0204, 1'b1, 32'h0, 4'hF);
    applyStimulus(1'b1, 32'h1C00_0204, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b1);
    step();
    applyStimulus(1'b1, 32'h1C00_0208, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    checkOutput("full_outstanding", {62'h0, outstanding_o}, 64'h2);
    checkOutput("full_blocks_req", {62'h0, l2_req_o, instr_gnt_o}, 64'h0);
    step();
    expGrant(1'b0, 32'h1C00_0208, 1'b1, 32'h0, 4'hF);
    expRsp(1'b0, 32'hAAAA_0001);
    l2_r_valid_i = 1'b1;
    l2_r_rdata_i = 32'hAAAA_0001;
    @(negedge clk);
    checkOutput("full_pop_push_req", {63'h0, l2_req_o}, 64'h1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b1);
    l2_r_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("full_pop_push_count", {62'h0, outstanding_o}, 64'h2);
    step();
    expRsp(1'b0, 32'hAAAA_0002);
    l2_r_valid_i = 1'b1;
    l2_r_rdata_i = 32'hAAAA_0002;
    step();
    expRsp(1'b0, 32'hAAAA_0003);
    l2_r_rdata_i = 32'hAAAA_0003;
    step();
    l2_r_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("full_drained", {62'h0, outstanding_o}, 64'h0);

    // Stalled data request keeps the selection while instr arrives
    step(); rst_i = 1'b1;
    step(); rst_i = 1'b0;
    autoResp = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_3000, 1'b1, 32'h0, 4'hF, 1'b0);
    @(negedge clk);
    checkOutput("hold_c0", {28'h0, l2_req_o, instr_gnt_o, data_gnt_o, l2_add_o}, {28'h0, 3'b100, 32'h0000_3000});
    for (int i = 1; i < 3; i++) begin
      step();
      applyStimulus(1'b1, 32'h1C00_0300, 1'b1, 32'h0000_3000, 1'b1, 32'h0, 4'hF, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("hold_c%0d", i), {28'h0, l2_req_o, instr_gnt_o, data_gnt_o, l2_add_o}, {28'h0, 3'b100, 32'h0000_3000});
    end
    step();
    expGrant(1'b1, 32'h0000_3000, 1'b1, 32'h0, 4'hF);
    expRsp(1'b1, 32'h1000_3000);
    applyStimulus(1'b1, 32'h1C00_0300, 1'b1, 32'h0000_3000, 1'b1, 32'h0, 4'hF, 1'b1);
    @(negedge clk);
    checkOutput("hold_release_gnt", {62'h0, instr_gnt_o, data_gnt_o}, 64'h1);
    step();
    expGrant(1'b0, 32'h1C00_0300, 1'b1, 32'h0, 4'hF);
    expRsp(1'b0, 32'h2C00_0300);
    applyStimulus(1'b1, 32'h1C00_0300, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b1);
    repeat (3) step();

    // Stray response with an empty FIFO sets a sticky error
    autoResp = 1'b0;
    l2_r_valid_i = 1'b1;
    l2_r_rdata_i = 32'hBAD0_BAD0;
    @(negedge clk);
    checkOutput("stray_err_before", {61'h0, outstanding_o, err_o}, 64'h0);
    step();
    l2_r_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("stray_err_set", {61'h0, outstanding_o, err_o}, 64'h1);
    repeat (2) step();
    @(negedge clk);
    checkOutput("stray_err_sticky", {63'h0, err_o}, 64'h1);

    // Reset with two outstanding discards them and restores instr priority
    expGrant(1'b0, 32'h1C00_0400, 1'b1, 32'h0, 4'hF);
    applyStimulus(1'b1, 32'h1C00_0400, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b1);
    step();
    expGrant(1'b0, 32'h1C00_0404, 1'b1, 32'h0, 4'hF);
    applyStimulus(1'b1, 32'h1C00_0404, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    checkOutput("prereset_state", {61'h0, outstanding_o, err_o}, 64'h5);
    step(); rst_i = 1'b1;
    step(); rst_i = 1'b0;
    autoResp = 1'b1;
    expGrant(1'b0, 32'h1C00_0500, 1'b1, 32'h0, 4'hF);
    expRsp(1'b0, 32'h2C00_0500);
    applyStimulus(1'b1, 32'h1C00_0500, 1'b1, 32'h0000_5000, 1'b0, 32'h0BAD_F00D, 4'hC, 1'b1);
    @(negedge clk);
    checkOutput("postreset_state", {61'h0, outstanding_o, err_o}, 64'h0);
    checkOutput("postreset_first_win", {62'h0, instr_gnt_o, data_gnt_o}, 64'h2);
    step();
    expGrant(1'b1, 32'h0000_5000, 1'b0, 32'h0BAD_F00D, 4'hC);
    expRsp(1'b1, 32'h1000_5000);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_5000, 1'b0, 32'h0BAD_F00D, 4'hC, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b1);

    budget = 0;
    while ((gntQ.size() != 0 || rspQ.size() != 0) && budget < 20) begin
      step();
      budget++;
    end
    @(negedge clk);
    checkOutput("final_grants_left", 64'(gntQ.size()), 64'h0);
    checkOutput("final_rsps_left", 64'(rspQ.size()), 64'h0);
    checkOutput("final_outstanding", {62'h0, outstanding_o}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
